// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: pixel strobe in, sync/coordinate/pulse outputs (frame_cnt only with FRAME_CNT_EN)
interface vga_sync_gen_if;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] x;
  logic [9:0] y;
  logic       line_start;
  logic       frame_start;
`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt;
  modport master(input pix_en, output hsync, vsync, video_on, x, y, line_start, frame_start, frame_cnt);
  modport slave(output pix_en, input hsync, vsync, video_on, x, y, line_start, frame_start, frame_cnt);
`else
  modport master(input pix_en, output hsync, vsync, video_on, x, y, line_start, frame_start);
  modport slave(output pix_en, input hsync, vsync, video_on, x, y, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator advancing one pixel per pix_en strobe; FRAME_CNT_EN adds frame_cnt
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input logic            clk50Mhz,
  input logic            rst,
  vga_sync_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_FP_AT = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_AT = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_BP_AT = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_FP_AT = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_AT = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_BP_AT = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} phase_t;
  phase_t h_state, h_next, v_state, v_next;
  logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt, x_d, y_d;
  logic started, hsync_d, vsync_d, video_d, ls_d, fs_d;
  always_ff @(posedge clk50Mhz or posedge rst)
    if (rst) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      started         <= 1'b0;
      h_state         <= ACTIVE;
      v_state         <= ACTIVE;
      vga.hsync       <= ~SYNC_POL;
      vga.vsync       <= ~SYNC_POL;
      vga.video_on    <= 1'b0;
      vga.x           <= '0;
      vga.y           <= '0;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
`ifdef FRAME_CNT_EN
      vga.frame_cnt   <= '0;
`endif
    end else begin
      vga.line_start  <= vga.pix_en && ls_d;
      vga.frame_start <= vga.pix_en && fs_d;
      if (vga.pix_en) begin
        started      <= 1'b1;
        h_cnt        <= h_nxt;
        v_cnt        <= v_nxt;
        h_state      <= h_next;
        v_state      <= v_next;
        vga.hsync    <= hsync_d;
        vga.vsync    <= vsync_d;
        vga.video_on <= video_d;
        vga.x        <= x_d;
        vga.y        <= y_d;
`ifdef FRAME_CNT_EN
        vga.frame_cnt <= vga.frame_cnt + 16'(fs_d);
`endif
      end
    end
  // The first strobe after reset presents (0,0) without advancing the counters.
  always_comb begin
    h_nxt  = !started ? h_cnt : h_cnt == H_LAST ? '0 : h_cnt + 10'd1;
    v_nxt  = (!started || h_cnt != H_LAST) ? v_cnt : v_cnt == V_LAST ? '0 : v_cnt + 10'd1;
    h_next = h_nxt == '0 ? ACTIVE : h_nxt == H_FP_AT ? FP : h_nxt == H_SYNC_AT ? SYNC :
             h_nxt == H_BP_AT ? BP : h_state;
    v_next = v_nxt == '0 ? ACTIVE : v_nxt == V_FP_AT ? FP : v_nxt == V_SYNC_AT ? SYNC :
             v_nxt == V_BP_AT ? BP : v_state;
  end
  always_comb begin
    video_d = h_next == ACTIVE && v_next == ACTIVE;
    hsync_d = h_next == SYNC ? SYNC_POL : ~SYNC_POL;
    vsync_d = v_next == SYNC ? SYNC_POL : ~SYNC_POL;
    x_d     = video_d ? h_nxt : '0;
    y_d     = video_d ? v_nxt : '0;
    ls_d    = h_nxt == '0 && v_next == ACTIVE;
    fs_d    = ls_d && v_nxt == '0;
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks on a full-size 640x480 instance and a tiny-timing instance for frame wrap
module tb_vga_sync_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  vga_sync_gen_if a();
  vga_sync_gen_if b();
  assign a.pix_en = pix_en;
  assign b.pix_en = pix_en;
  always #5 clk = ~clk;
  vga_sync_gen dut_a (.clk50Mhz(clk), .rst(rst), .vga(a));
  // Tiny timing: H 8/2/3/2 (total 15), V 6/2/2/1 (total 11), active-high sync
  vga_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(2),
                 .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1))
    dut_b (.clk50Mhz(clk), .rst(rst), .vga(b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic run(input int n);
    pix_en = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    pix_en = 1'b0;
  endtask
  task automatic run_gapped(input int n);
    repeat (n) begin
      run(1);
      tick(1);
    end
  endtask
  initial begin
    int seen;
    tick(2);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      tick(1);
      seen += int'(a.line_start | a.frame_start);
    end
    chk("idle_pulses", seen, 0);
    chk("rst_hsync", a.hsync, 1);
    chk("rst_vsync", a.vsync, 1);
    chk("rst_video", a.video_on, 0);
    chk("rst_x", a.x, 0);
    chk("rst_y", a.y, 0);
    run(1);
    chk("first_video", a.video_on, 1);
    chk("first_x", a.x, 0);
    chk("first_y", a.y, 0);
    chk("first_ls", a.line_start, 1);
    chk("first_fs", a.frame_start, 1);
`ifdef FRAME_CNT_EN
    chk("first_fcnt", a.frame_cnt, 1);
`endif
    tick(1);
    chk("ls_width", a.line_start, 0);
    chk("fs_width", a.frame_start, 0);
    chk("hold_video", a.video_on, 1);
    run_gapped(639);
    chk("x639", a.x, 639);
    chk("x639_video", a.video_on, 1);
    run_gapped(1);
    chk("h640_video", a.video_on, 0);
    chk("h640_x", a.x, 0);
    run_gapped(15);
    chk("h655_hsync", a.hsync, 1);
    run_gapped(1);
    chk("h656_hsync", a.hsync, 0);
    run_gapped(95);
    chk("h751_hsync", a.hsync, 0);
    run_gapped(1);
    chk("h752_hsync", a.hsync, 1);
    run_gapped(47);
    chk("h799_video", a.video_on, 0);
    chk("h799_ls", a.line_start, 0);
    run(1);
    chk("l1_x", a.x, 0);
    chk("l1_y", a.y, 1);
    chk("l1_video", a.video_on, 1);
    chk("l1_ls", a.line_start, 1);
    chk("l1_fs", a.frame_start, 0);
    tick(1);
    chk("l1_ls_clear", a.line_start, 0);
    run(10);
    chk("cont_x", a.x, 10);
    tick(5);
    chk("frozen_x", a.x, 10);
    chk("frozen_y", a.y, 1);
    for (int i = 0; i < 10; i++) begin
      run(1);
      tick($urandom_range(0, 3));
    end
    chk("rand_gap_x", a.x, 20);
    chk("rand_gap_y", a.y, 1);
    run(280);
    chk("pre_rst_x", a.x, 300);
    rst = 1'b1;
    #1;
    chk("async_rst_x", a.x, 0);
    chk("async_rst_y", a.y, 0);
    chk("async_rst_video", a.video_on, 0);
    chk("async_rst_hsync", a.hsync, 1);
    tick(2);
    rst = 1'b0;
    tick(2);
    run(1);
    chk("restart_fs", a.frame_start, 1);
    chk("restart_x", a.x, 0);
    chk("restart_y", a.y, 0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("s_rst_hsync", b.hsync, 0);
    chk("s_rst_vsync", b.vsync, 0);
    run(1);
    chk("s_first_fs", b.frame_start, 1);
    run(10);
    chk("s_h10_hsync", b.hsync, 1);
    chk("s_h10_video", b.video_on, 0);
    run(95);
    chk("s_v7_vsync", b.vsync, 0);
    chk("s_v7_ls", b.line_start, 0);
    chk("s_v7_y", b.y, 0);
    run(15);
    chk("s_v8_vsync", b.vsync, 1);
    run(30);
    chk("s_v10_vsync", b.vsync, 0);
    run(14);
    chk("s_last_fs", b.frame_start, 0);
    run(1);
    chk("s_wrap_fs", b.frame_start, 1);
    chk("s_wrap_ls", b.line_start, 1);
    chk("s_wrap_video", b.video_on, 1);
    chk("s_wrap_x", b.x, 0);
    chk("s_wrap_y", b.y, 0);
`ifdef FRAME_CNT_EN
    chk("s_fcnt", b.frame_cnt, 2);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- VGA 640x480@60 timing generator.
- Sits directly downstream of the 25 MHz pixel-rate divider and consumes its one-cycle pixel strobe.
- Runs in the clk50Mhz domain and advances one pixel per strobe.
- Drives hsync/vsync to the connector and pixel coordinates plus video_on to the pixel/ROM read stage.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low)

Ports:
- clk50Mhz  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel strobe from the divider; high for one clk50Mhz cycle per pixel; may be held high continuously
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  current pixel is in the active area
- x  out  10  active-area column, 0..H_ACTIVE-1
- y  out  10  active-area row, 0..V_ACTIVE-1
- line_start  out  1  one-cycle pulse when x=0 is presented
- frame_start  out  1  one-cycle pulse when pixel (0,0) is presented
- frame_cnt  out  16  frames presented (only with FRAME_CNT_EN)

Behaviour:
- Reset values: internal h_cnt=0, v_cnt=0, started=0, hsync=vsync=~SYNC_POL, video_on=0, x=0, y=0, line_start=0, frame_start=0, frame_cnt=0.
- All outputs are registered and change only on a clk50Mhz edge where pix_en=1.
- Exception: line_start and frame_start clear on the next clk50Mhz edge whatever pix_en is, so they are always exactly one clk50Mhz cycle wide.
- First pix_en after reset: presents pixel (0,0); started goes to 1; the counters do not advance on that edge.
- Each later pix_en: h_cnt advances. H_TOTAL=800, V_TOTAL=525 derived from the parameters.
  - If h_cnt=H_TOTAL-1: h_cnt wraps to 0 and v_cnt advances.
  - If v_cnt=V_TOTAL-1 at that wrap: v_cnt wraps to 0.
- Horizontal FSM states: ACTIVE, FP, SYNC, BP. Transitions are on h_cnt boundaries: 0 -> ACTIVE, 640 -> FP, 656 -> SYNC, 752 -> BP, back to ACTIVE at the wrap.
- Vertical uses the same state set on v_cnt boundaries: 0, 480, 490, 492.
- Output decode, registered from the pixel being presented:
  - hsync=SYNC_POL iff h in [656,751].
  - vsync=SYNC_POL iff v in [490,491].
  - video_on=1 iff h<640 and v<480.
  - x=h and y=v while video_on=1; otherwise x and y hold 0.
- line_start=1 when the presented pixel has h=0 and v<480.
- frame_start=1 when the presented pixel is h=0, v=0. line_start also pulses for that pixel.
- pix_en=0: all counters and levels hold; no wrap or pulse is generated.
- Reset asserted mid-frame: everything returns to reset values immediately. The frame restarts at (0,0) on the first pix_en after release.
- Counter arithmetic is 10-bit unsigned; no value reaches 1024.

Optional Feature:
- Macro FRAME_CNT_EN.
- Defined: port frame_cnt exists. It increments by 1, modulo 2^16, in the same cycle each frame_start is asserted. It is 1 after the first frame_start and wraps from 65535 to 0.
- Undefined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- Reset, then no pix_en for 20 cycles -> hsync=vsync=1, video_on=0, x=y=0, no pulses.
- First pix_en -> next edge shows video_on=1, x=0, y=0, line_start=1, frame_start=1 for exactly one cycle. With FRAME_CNT_EN, frame_cnt=1.
- pix_en every 2nd cycle, sweep line 0:
  - x=639 -> video_on drops at h=640.
  - hsync goes 0 at h=656 and returns to 1 at h=752.
  - After h=799, next pix_en gives x=0, y=1 with a line_start pulse.
- Run to v=489/490/492 -> vsync 1/0/1. At (799,524) the next pix_en gives (0,0) with frame_start=1. Second frame_start arrives 420000 pix_en strobes after the first.
- pix_en held high continuously vs. with random gaps -> identical output sequences per strobe; outputs frozen during gaps.
- Assert rst at pixel (300,200) -> outputs at reset values within the same cycle. After release and one pix_en: (0,0), frame_start=1.
